// File: rtl/node_out_arbiter.sv
// Output-port scheduler for one MAZE node direction.
// QoS round-robin arbiter with starvation guard and a one-entry output register.
//
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   req_vld    per-requester packet valid (0=N 1=W 2=S 3=E 4=local)
//   req_pkt    per-requester packets, slice i = [i*PW +: PW]
//   req_rdy    one-hot accept strobe (combinational)
//   out_blk    downstream faulty/disabled: no new grants
//   out_vld    registered output valid
//   out_pkt    registered output packet
//   out_rdy    downstream ready
//   grant_id   requester index that loaded out_pkt
module node_out_arbiter #(
  parameter int NREQ       = 5,
  parameter int PW         = 23,
  parameter int STARVE_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [NREQ*PW-1:0]   req_pkt,
  output logic [NREQ-1:0]      req_rdy,
  input  logic                 out_blk,
  output logic                 out_vld,
  output logic [PW-1:0]        out_pkt,
  input  logic                 out_rdy,
  output logic [2:0]           grant_id
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int QB = 20;

  logic [IW-1:0]   rr_ptr;
  logic [SW-1:0]   starve_cnt;
  logic [SW-1:0]   starve_nxt;
  logic [NREQ-1:0] qos_v;
  logic [NREQ-1:0] v1;
  logic [NREQ-1:0] v0;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] hi;
  logic [IW-1:0]   win_hi;
  logic [IW-1:0]   win_lo;
  logic [IW-1:0]   win;
  logic [PW-1:0]   sel_pkt;
  logic            starved;
  logic            load_en;
  logic            grant;
  logic            win_qos;

  always_comb begin
    qos_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      qos_v[i] = req_pkt[i*PW+QB];
    end
  end

  assign v1 = req_vld & qos_v;
  assign v0 = req_vld & ~qos_v;

  assign starved = (starve_cnt == SW'(STARVE_MAX)) && (|v0);

  always_comb begin
    cand = req_vld;
    if (starved) begin
      cand = v0;
    end else if (|v1) begin
      cand = v1;
    end
  end

  // Round-robin: candidates above rr_ptr first, else wrap to lowest.
  always_comb begin
    hi = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi[i] = cand[i] && (i > int'(rr_ptr));
    end
  end

  always_comb begin
    win_hi = '0;
    win_lo = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (hi[i]) win_hi = IW'(i);
      if (cand[i]) win_lo = IW'(i);
    end
  end

  assign win = (|hi) ? win_hi : win_lo;

  always_comb begin
    sel_pkt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) sel_pkt = req_pkt[i*PW +: PW];
    end
  end

  assign win_qos = sel_pkt[QB];

  // Reset also masks grants so no requester sees an accept.
  assign load_en = !rst && !out_blk && (!out_vld || out_rdy);
  assign grant   = load_en && (|req_vld);

  always_comb begin
    req_rdy = '0;
    if (grant) begin
      for (int i = 0; i < NREQ; i++) begin
        if (win == IW'(i)) req_rdy[i] = 1'b1;
      end
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (!(|v0)) begin
      starve_nxt = '0;
    end else if (grant && !win_qos) begin
      starve_nxt = '0;
    end else if (grant && starve_cnt != SW'(STARVE_MAX)) begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld    <= 1'b0;
      out_pkt    <= '0;
      grant_id   <= '0;
      rr_ptr     <= IW'(NREQ - 1);
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      if (grant) begin
        out_vld  <= 1'b1;
        out_pkt  <= sel_pkt;
        grant_id <= 3'(win);
        rr_ptr   <= win;
      end else if (out_vld && out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule
